// File: rtl/lv1_lv2_bus_arbiter_if.sv
// rtl/lv1_lv2_bus_arbiter_if.sv - L1-to-L2 bus request/grant bundle.
// master = L1 requester side, slave = arbiter side.
interface lv1_lv2_bus_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int REQ_ID_WID = 3
);
  logic [NUM_CORES-1:0]  bus_lv1_lv2_req_proc_il;
  logic [NUM_CORES-1:0]  bus_lv1_lv2_req_proc_dl;
  logic [NUM_CORES-1:0]  bus_lv1_lv2_gnt_proc_il;
  logic [NUM_CORES-1:0]  bus_lv1_lv2_gnt_proc_dl;
  logic [REQ_ID_WID-1:0] bus_lv1_lv2_owner;
  logic                  bus_lv1_lv2_busy;

  modport master (
    output bus_lv1_lv2_req_proc_il, bus_lv1_lv2_req_proc_dl,
    input  bus_lv1_lv2_gnt_proc_il, bus_lv1_lv2_gnt_proc_dl,
    input  bus_lv1_lv2_owner, bus_lv1_lv2_busy
  );

  modport slave (
    input  bus_lv1_lv2_req_proc_il, bus_lv1_lv2_req_proc_dl,
    output bus_lv1_lv2_gnt_proc_il, bus_lv1_lv2_gnt_proc_dl,
    output bus_lv1_lv2_owner, bus_lv1_lv2_busy
  );
endinterface

// File: rtl/lv1_lv2_bus_arbiter.sv
// rtl/lv1_lv2_bus_arbiter.sv - round-robin owner-holds arbiter for the shared L1-to-L2 bus.
// Optional ARB_TIMEOUT_EN forces handover after MAX_HOLD ownership cycles when others wait.
module lv1_lv2_bus_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int REQ_ID_WID = 3,
  parameter int MAX_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  lv1_lv2_bus_arbiter_if.slave  bus
);
  localparam int N = 2 * NUM_CORES;

  if (REQ_ID_WID != $clog2(N)) begin : g_id_wid_chk
    $error("REQ_ID_WID must equal clog2(2*NUM_CORES)");
  end
  if (MAX_HOLD < 1) begin : g_max_hold_chk
    $error("MAX_HOLD must be at least 1");
  end

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [REQ_ID_WID-1:0] r_owner, w_owner_nxt;
  logic [REQ_ID_WID-1:0] r_rr_ptr, w_rr_nxt;
  logic [REQ_ID_WID-1:0] w_owner_inc;
  logic [N-1:0]          w_req;
  logic [N-1:0]          r_gnt, w_gnt_nxt;
  logic                  r_busy;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_WID = $clog2(MAX_HOLD) + 1;
  logic [HOLD_WID-1:0] r_hold_cnt, w_hold_nxt;
  logic [N-1:0]        w_others;
`endif

  // First set bit at or above start, wrapping N-1 -> 0; N need not be a power of two.
  function automatic logic [REQ_ID_WID-1:0] f_rr_pick(input logic [N-1:0] req,
                                                      input logic [REQ_ID_WID-1:0] start);
    logic [REQ_ID_WID-1:0] pick;
    logic [REQ_ID_WID-1:0] pos;
    logic                  found;
    int                    idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      pos = REQ_ID_WID'(idx);
      if (!found && req[pos]) begin
        pick  = pos;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [REQ_ID_WID-1:0] f_inc(input logic [REQ_ID_WID-1:0] v);
    int t;
    t = int'(v) + 1;
    if (t >= N) t = 0;
    return REQ_ID_WID'(t);
  endfunction

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_map
    assign w_req[2*c]                      = bus.bus_lv1_lv2_req_proc_il[c];
    assign w_req[2*c+1]                    = bus.bus_lv1_lv2_req_proc_dl[c];
    assign bus.bus_lv1_lv2_gnt_proc_il[c]  = r_gnt[2*c];
    assign bus.bus_lv1_lv2_gnt_proc_dl[c]  = r_gnt[2*c+1];
  end

  assign bus.bus_lv1_lv2_owner = r_owner;
  assign bus.bus_lv1_lv2_busy  = r_busy;
  assign w_owner_inc           = f_inc(r_owner);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt  = r_hold_cnt;
    w_others    = w_req & ~(N'(1) << r_owner);
`endif
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = f_rr_pick(w_req, r_rr_ptr);
`ifdef ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!w_req[r_owner]) begin
          // Release: search from owner+1 so the old owner ranks last; no idle bubble.
          w_rr_nxt = w_owner_inc;
          if (|w_req) begin
            w_owner_nxt = f_rr_pick(w_req, w_owner_inc);
`ifdef ARB_TIMEOUT_EN
            w_hold_nxt  = '0;
`endif
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold_cnt == HOLD_WID'(MAX_HOLD - 1)) begin
          if (|w_others) begin
            w_rr_nxt    = w_owner_inc;
            w_owner_nxt = f_rr_pick(w_others, w_owner_inc);
            w_hold_nxt  = '0;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_WID'(1);
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_gnt_nxt = (w_state_nxt == ST_GRANT) ? (N'(1) << w_owner_nxt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_busy     <= (w_state_nxt == ST_GRANT);
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// tb/tb_lv1_lv2_bus_arbiter.sv - self-checking bench for lv1_lv2_bus_arbiter (ARB_TIMEOUT_EN aware).
// Reference model tracks owner/pointer from the arbitration rules with plain integer arithmetic.
module tb_lv1_lv2_bus_arbiter;
  localparam int NC = 4;
  localparam int N  = 2 * NC;
  localparam int IW = 3;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 64;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lv1_lv2_bus_arbiter_if #(.NUM_CORES(NC), .REQ_ID_WID(IW)) bus ();

  lv1_lv2_bus_arbiter #(.NUM_CORES(NC), .REQ_ID_WID(IW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [N-1:0] got_gnt;
  always_comb begin
    got_gnt = '0;
    for (int c = 0; c < NC; c++) begin
      got_gnt[2*c]   = bus.bus_lv1_lv2_gnt_proc_il[c];
      got_gnt[2*c+1] = bus.bus_lv1_lv2_gnt_proc_dl[c];
    end
  end

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_hold;
  logic [N-1:0] exp_gnt;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int i = 0; i < N; i++)
      if (r[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_hold = 0; exp_gnt = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int p;
    if (!m_busy) begin
      p = pick(r, m_rr);
      if (p >= 0) begin m_busy = 1; m_owner = p; m_hold = 0; end
    end else if (!r[m_owner]) begin
      m_rr = (m_owner + 1) % N;
      p = pick(r, m_rr);
      if (p >= 0) begin m_owner = p; m_hold = 0; end
      else m_busy = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      logic [N-1:0] others;
      others = r;
      others[m_owner] = 1'b0;
      if (m_hold == MH - 1) begin
        if (others != 0) begin
          m_rr = (m_owner + 1) % N;
          m_owner = pick(others, m_rr);
          m_hold = 0;
        end
      end else begin
        m_hold++;
      end
`endif
    end
    exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
  endtask

  task automatic drive(input logic [N-1:0] r);
    for (int c = 0; c < NC; c++) begin
      bus.bus_lv1_lv2_req_proc_il[c] = r[2*c];
      bus.bus_lv1_lv2_req_proc_dl[c] = r[2*c+1];
    end
  endtask

  task automatic tick(input logic [N-1:0] r);
    drive(r);
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive('0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (got_gnt !== '0 || bus.bus_lv1_lv2_busy !== 1'b0 || bus.bus_lv1_lv2_owner !== '0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b busy=%b owner=%0d required gnt=0 busy=0 owner=0",
               got_gnt, bus.bus_lv1_lv2_busy, bus.bus_lv1_lv2_owner);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) tick(8'b0000_0100);
    n_checks++;
    if (got_gnt !== 8'b0000_0100 || bus.bus_lv1_lv2_owner !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_pre_grant: gnt=%b owner=%0d required gnt=00000100 owner=2",
               got_gnt, bus.bus_lv1_lv2_owner);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (got_gnt !== '0 || bus.bus_lv1_lv2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_drop: gnt=%b busy=%b required 0/0", got_gnt, bus.bus_lv1_lv2_busy);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    tick(8'b0000_0100);
    n_checks++;
    if (got_gnt !== 8'b0000_0100 || bus.bus_lv1_lv2_busy !== 1'b1 || bus.bus_lv1_lv2_owner !== 3'd2) begin
      n_fail++;
      $display("FAIL reset_regrant: gnt=%b busy=%b owner=%0d required gnt=00000100 busy=1 owner=2",
               got_gnt, bus.bus_lv1_lv2_busy, bus.bus_lv1_lv2_owner);
    end
  endtask

  task automatic test_single();
    int idx;
    logic [N-1:0] r;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      idx = (k == 0) ? 5 : int'($urandom_range(N - 1));
      for (int cyc = 0; cyc < 10; cyc++) begin
        r = (cyc >= 1 && cyc < 6) ? (N'(1) << idx) : '0;
        tick(r);
        n_checks++;
        if (got_gnt !== exp_gnt || bus.bus_lv1_lv2_busy !== m_busy ||
            (m_busy && int'(bus.bus_lv1_lv2_owner) != m_owner)) begin
          n_fail++;
          $display("FAIL single idx=%0d cyc=%0d: gnt=%b busy=%b owner=%0d required gnt=%b busy=%b owner=%0d",
                   idx, cyc, got_gnt, bus.bus_lv1_lv2_busy, bus.bus_lv1_lv2_owner, exp_gnt, m_busy, m_owner);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int owners[$];
    int cur, held, iter;
    logic [N-1:0] r;
    do_reset();
    cur = -1; held = 0; iter = 0;
    while (owners.size() < 9 && iter < 60) begin
      r = '1;
      if (held == 3) r[cur] = 1'b0;
      tick(r);
      iter++;
      n_checks++;
      if (got_gnt !== exp_gnt || bus.bus_lv1_lv2_busy !== 1'b1 || $countones(got_gnt) != 1) begin
        n_fail++;
        $display("FAIL simultaneous iter=%0d: gnt=%b busy=%b required gnt=%b busy=1",
                 iter, got_gnt, bus.bus_lv1_lv2_busy, exp_gnt);
      end
      if (int'(bus.bus_lv1_lv2_owner) != cur) begin
        cur = int'(bus.bus_lv1_lv2_owner);
        owners.push_back(cur);
        held = 1;
      end else begin
        held++;
      end
    end
    n_checks++;
    if (owners.size() != 9) begin
      n_fail++;
      $display("FAIL simultaneous_count: saw %0d owners required 9", owners.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (owners[i] != i % N) begin
          n_fail++;
          $display("FAIL simultaneous_seq[%0d]: owner=%0d required %0d", i, owners[i], i % N);
        end
      end
    end
  endtask

  task automatic test_hold_priority();
    logic [N-1:0] r;
    do_reset();
    tick(8'b0000_0001);
    for (int cyc = 0; cyc < 22; cyc++) begin
      r = (cyc < 20) ? 8'b1000_0001 : 8'b1000_0000;
      tick(r);
      n_checks++;
      if (got_gnt !== exp_gnt || (m_busy && int'(bus.bus_lv1_lv2_owner) != m_owner)) begin
        n_fail++;
        $display("FAIL hold_priority cyc=%0d: gnt=%b owner=%0d required gnt=%b owner=%0d",
                 cyc, got_gnt, bus.bus_lv1_lv2_owner, exp_gnt, m_owner);
      end
    end
`ifndef ARB_TIMEOUT_EN
    n_checks++;
    if (bus.bus_lv1_lv2_owner !== 3'd7 || got_gnt !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL hold_handover: owner=%0d gnt=%b required owner=7 gnt=10000000",
               bus.bus_lv1_lv2_owner, got_gnt);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    tick(8'b1000_0000);
    tick(8'b1100_0001);
    tick(8'b1100_0001);
    tick(8'b0100_0001);
    n_checks++;
    if (got_gnt !== 8'b0000_0001 || bus.bus_lv1_lv2_owner !== 3'd0 || got_gnt !== exp_gnt) begin
      n_fail++;
      $display("FAIL wrap: gnt=%b owner=%0d required gnt=00000001 owner=0",
               got_gnt, bus.bus_lv1_lv2_owner);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      r = N'($urandom) & N'($urandom);
      if (m_busy && ($urandom_range(3) != 0)) r[m_owner] = 1'b1;
      tick(r);
      n_checks++;
      if (got_gnt !== exp_gnt || bus.bus_lv1_lv2_busy !== m_busy ||
          (m_busy && int'(bus.bus_lv1_lv2_owner) != m_owner)) begin
        n_fail++;
        $display("FAIL random cyc=%0d req=%b: gnt=%b busy=%b owner=%0d required gnt=%b busy=%b owner=%0d",
                 cyc, r, got_gnt, bus.bus_lv1_lv2_busy, bus.bus_lv1_lv2_owner, exp_gnt, m_busy, m_owner);
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    tick(8'b0000_0001);
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick(8'b0000_0101);
      n_checks++;
      if (bus.bus_lv1_lv2_owner !== ((cyc < 3) ? 3'd0 : 3'd2) || got_gnt !== exp_gnt) begin
        n_fail++;
        $display("FAIL timeout_force cyc=%0d: owner=%0d gnt=%b required owner=%0d",
                 cyc, bus.bus_lv1_lv2_owner, got_gnt, (cyc < 3) ? 0 : 2);
      end
    end
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick(8'b0000_0001);
      n_checks++;
      if (got_gnt !== 8'b0000_0001 || bus.bus_lv1_lv2_owner !== 3'd0) begin
        n_fail++;
        $display("FAIL timeout_alone cyc=%0d: owner=%0d gnt=%b required owner=0 gnt=00000001",
                 cyc, bus.bus_lv1_lv2_owner, got_gnt);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    model_reset();
    drive('0);
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_priority();
    test_wrap();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lv1_lv2_bus_arbiter.md
Name: lv1_lv2_bus_arbiter

Overview:
- Round-robin arbiter for the shared L1-to-L2 bus.
- Requesters are the L1 instruction-side and data-side processor paths of every core.
- Consumes each L1 block's bus request (e.g. bus_lv1_lv2_req_proc_il) and drives the grant that L1 block waits on before it places lv2_rd and addr_bus_lv1_lv2.
- Exactly one requester owns the bus at a time. Ownership is held until that requester drops its request.

Parameters:
- NUM_CORES, 4, number of cores; requester count N = 2*NUM_CORES.
- REQ_ID_WID, 3, width of the owner index; equals clog2(2*NUM_CORES).
- MAX_HOLD, 64, maximum consecutive ownership cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- bus_lv1_lv2_req_proc_il  input  NUM_CORES  IL request; bit c = core c.
- bus_lv1_lv2_req_proc_dl  input  NUM_CORES  DL request; bit c = core c.
- bus_lv1_lv2_gnt_proc_il  output  NUM_CORES  IL grant, one-hot across both grant vectors.
- bus_lv1_lv2_gnt_proc_dl  output  NUM_CORES  DL grant.
- bus_lv1_lv2_owner  output  REQ_ID_WID  index of the current owner; valid when bus_lv1_lv2_busy=1.
- bus_lv1_lv2_busy  output  1  a grant is asserted.

Behaviour:
- Requester index mapping: index 2c = IL of core c; index 2c+1 = DL of core c. Unified request vector req[N-1:0].
- Reset (async, rst=1): all grants 0, busy 0, owner 0, rr_ptr 0, hold counter 0. Outputs change immediately on rst assertion, without waiting for clk.
- All outputs are registered. A request sampled at edge t gives a grant visible after edge t. Minimum latency is 1 cycle from request to grant when the bus is idle.
- State machine states:
  - IDLE: no grant.
    - Any req bit set -> GRANT. The owner is the first set bit searching upward from rr_ptr, wrapping at N-1 -> 0.
  - GRANT: grant[owner]=1.
    - req[owner] still 1 -> stay in GRANT, owner unchanged, regardless of other requests.
    - req[owner]=0 -> rr_ptr <= owner+1 mod N.
      - Another req bit set at the same edge -> stay in GRANT with the new owner. The search starts at owner+1, so the old owner gets lowest priority. No idle bubble.
      - No other req bit set -> IDLE, busy 0.
- One-hot invariant: at most one bit across both grant vectors is ever set. Busy = OR of all grant bits.
- Grant is never removed while the owner's request is high, except on reset or timeout.
- A request pulse that drops before it is granted is lost. The arbiter keeps no pending memory.
- Simultaneous requests at a cycle-aligned start from IDLE with rr_ptr=0: the lowest index wins (core0 IL before core0 DL before core1 IL ...).
- Wrap-around: rr_ptr = N-1 with owner N-1 released -> rr_ptr wraps to 0.
- Reset mid-grant: the grant drops asynchronously. Requests still high after rst deasserts are arbitrated fresh from rr_ptr=0.
- Owner index width: owner+1 is computed modulo N. N need not be a power of two.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - hold_cnt counts cycles in GRANT with an unchanged owner.
  - When hold_cnt reaches MAX_HOLD-1 and other requests are pending, ownership is forcibly passed as if the owner had released: rr_ptr <= owner+1 and the next requester is granted. hold_cnt resets to 0.
  - If no other request is pending, the owner keeps the bus and hold_cnt saturates.
  - A forced owner that still holds its request re-arbitrates normally later.
- When undefined: no counter exists; ownership is unbounded; MAX_HOLD is ignored.

Test Plan:
- Reset: assert rst mid-grant with core1 IL owning -> all grants 0 and busy 0 immediately. After release, core1 IL still requesting is regranted one cycle later with owner=2.
- Single request: core2 DL req=1 at cycle 5 -> gnt_proc_dl[2]=1 and owner=5 from cycle 6. Req drops at cycle 10 -> grant 0 and busy 0 at cycle 11.
- Simultaneous requests: all 8 reqs rise together from reset -> owner sequence 0,1,2,...,7,0 as each owner drops its req after 3 cycles. Back-to-back handover with no idle cycle; the one-hot check passes every cycle.
- Hold priority: core0 IL owns; core3 DL requests for 20 cycles -> grant stays with core0 IL until its req drops, then goes to core3 DL the next cycle.
- Wrap-around: owner 7 releases while reqs 0 and 6 are pending -> owner 0 is granted (rr_ptr=0), not owner 6.
- ARB_TIMEOUT_EN, MAX_HOLD=4: core0 IL holds its req while core1 IL requests -> grant moves to index 2 after 4 ownership cycles. Repeat with no competing request -> core0 IL keeps the grant indefinitely.
